// File: rtl/dcc_axil_cmd_fifo.sv
// AXI4-Lite DCC command FIFO: CTRL/STATUS/TXDATA/THRESH registers feeding a valid/ready stream.
// Optional low-water interrupt output is built when DCC_CMD_IRQ_EN is defined.
module dcc_axil_cmd_fifo #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int DEPTH              = 16
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
`ifdef DCC_CMD_IRQ_EN
  output logic                            irq,
`endif
  output logic [C_S_AXI_DATA_WIDTH-1:0]   m_cmd_data,
  output logic                            m_cmd_valid,
  input  logic                            m_cmd_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d, thr_q, thr_d;
  logic          en_q, en_d, ovf_q, ovf_d;
  logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]   rdata_q, rdata_d;

  logic wr_acc, rd_acc, wr_hit, rd_hit;
  logic empty, full, pop, push, flush, wr_err;
  logic unused_ok;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign wr_acc = s00_axi_awvalid && s00_axi_wvalid &&
                  !bvalid_q && !s00_axi_areset;
  assign rd_acc = s00_axi_arvalid && !rvalid_q && !s00_axi_areset;
  assign wr_hit = (s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:4] == '0);
  assign rd_hit = (s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:4] == '0);

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign pop   = en_q && !empty && m_cmd_ready;

  assign s00_axi_awready = wr_acc;
  assign s00_axi_wready  = wr_acc;
  assign s00_axi_arready = rd_acc;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rdata   = rdata_q;
  assign m_cmd_valid     = en_q && !empty;
  assign m_cmd_data      = mem_q[rptr_q];

  always_comb begin
    en_d   = en_q;
    ovf_d  = ovf_q;
    thr_d  = thr_q;
    push   = 1'b0;
    flush  = 1'b0;
    wr_err = 1'b0;
    if (wr_acc) begin
      if (!wr_hit) begin
        wr_err = 1'b1;
      end else begin
        case (s00_axi_awaddr[3:2])
          2'd0: if (s00_axi_wstrb[0]) begin
            en_d  = s00_axi_wdata[0];
            flush = s00_axi_wdata[1];
          end
          2'd1: if (s00_axi_wstrb[0] && s00_axi_wdata[2]) ovf_d = 1'b0;
          2'd2: begin
            if (s00_axi_wstrb != 4'hF) begin
              wr_err = 1'b1;
            end else if (full && !pop) begin
              // No room and nothing leaving: drop the word and flag it
              ovf_d  = 1'b1;
              wr_err = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
          default: if (s00_axi_wstrb[0]) thr_d = s00_axi_wdata[CW-1:0];
        endcase
      end
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (wr_acc) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_err ? SLVERR : OKAY;
    end else if (bvalid_q && s00_axi_bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rd_acc) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_hit ? OKAY : SLVERR;
      rdata_d  = '0;
      if (rd_hit) begin
        case (s00_axi_araddr[3:2])
          2'd0: rdata_d[0] = en_q;
          2'd1: begin
            rdata_d[0]      = empty;
            rdata_d[1]      = full;
            rdata_d[2]      = ovf_q;
            rdata_d[8 +: CW] = cnt_q;
          end
          2'd2:    rdata_d = '0;
          default: rdata_d[CW-1:0] = thr_q;
        endcase
      end
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (push) mem_q[wptr_q] <= s00_axi_wdata;
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      thr_q    <= '0;
      en_q     <= 1'b0;
      ovf_q    <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      thr_q    <= thr_d;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef DCC_CMD_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = en_q && (cnt_q <= thr_q);
  assign irq   = irq_q;

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) irq_q <= 1'b0;
    else                irq_q <= irq_d;
  end
`endif

endmodule
